// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with a valid/ready handshake, a
// two-entry (main + skid) buffer, a flush path and a writeback-control decode
// that is computed when an entry is captured and stored with it.
//
// Optional feature macro: MEM_WB_FWD_EN
//   defined   : fwd_* expose the main entry combinationally for EX-stage bypass
//   undefined : fwd_we_o=0, fwd_reg_o=NOP_REG, fwd_data_o=0 (no bypass logic)
//
// Ports:
//   clk_i, rst_i       clock (rising edge), synchronous active-high reset
//   flush_i            discard held and incoming entries
//   in_valid_i/in_ready_o, ir_i, alu_data_i, mem_data_i   MEM-side entry
//   out_valid_o/out_ready_i, ir_o, wb_we_o, wb_reg_o, wb_sel_o, wb_data_o
//                      WB-side entry (wb_we_o already qualified by valid)
//   fwd_we_o, fwd_reg_o, fwd_data_o   forwarding view of the main entry
//
// state   | meaning
// S_EMPTY | main and skid empty
// S_ONE   | main holds the oldest entry, skid empty
// S_FULL  | main and skid both hold entries, input stalled
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int IR_W    = 32,
  parameter int REG_W   = 5,
  parameter int NOP_REG = 31
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [IR_W-1:0]   ir_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IR_W-1:0]   ir_o,
  output logic              wb_we_o,
  output logic [REG_W-1:0]  wb_reg_o,
  output logic              wb_sel_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              fwd_we_o,
  output logic [REG_W-1:0]  fwd_reg_o,
  output logic [DATA_W-1:0] fwd_data_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [REG_W-1:0] NOP_IDX = REG_W'(NOP_REG);

  state_t state_q, state_d;

  logic main_valid;
  logic in_fire, out_fire;
  logic load_main, load_skid, move_skid;

  // Decoded view of the incoming entry
  logic [3:0]        in_op;
  logic              in_we;
  logic              in_sel;
  logic [REG_W-1:0]  in_reg;
  logic [DATA_W-1:0] in_data;

  logic [IR_W-1:0]   main_ir_q,   main_ir_d;
  logic              main_we_q,   main_we_d;
  logic [REG_W-1:0]  main_reg_q,  main_reg_d;
  logic              main_sel_q,  main_sel_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;

  logic [IR_W-1:0]   skid_ir_q,   skid_ir_d;
  logic              skid_we_q,   skid_we_d;
  logic [REG_W-1:0]  skid_reg_q,  skid_reg_d;
  logic              skid_sel_q,  skid_sel_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Control outputs; in_ready_o depends on the state register only
  always_comb begin
    main_valid = (state_q != S_EMPTY);
    in_ready_o = (state_q != S_FULL);
    in_fire    = in_valid_i & in_ready_o;
    out_fire   = main_valid & out_ready_i;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (!flush_i) begin
      unique case (state_q)
        S_EMPTY: load_main = in_fire;
        S_ONE: begin
          load_main = in_fire & out_fire;
          load_skid = in_fire & ~out_fire;
        end
        S_FULL:  move_skid = out_fire;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: if (in_fire) state_d = S_ONE;
        S_ONE: begin
          if (in_fire && !out_fire)      state_d = S_FULL;
          else if (out_fire && !in_fire) state_d = S_EMPTY;
        end
        S_FULL:  if (out_fire) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Writeback-control decode of the incoming instruction
  always_comb begin
    in_op = ir_i[IR_W-1 -: 4];
    unique case (in_op)
      4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9: in_we = 1'b1;
      default:                                  in_we = 1'b0;
    endcase
    in_sel  = (in_op != 4'd0);
    in_reg  = in_we ? ir_i[IR_W-5 -: REG_W] : NOP_IDX;
    in_data = in_sel ? alu_data_i : mem_data_i;
  end

  // Entry movement; fields hold when nothing is loaded so outputs stay put
  // while out_valid_o is low
  always_comb begin
    main_ir_d   = main_ir_q;
    main_we_d   = main_we_q;
    main_reg_d  = main_reg_q;
    main_sel_d  = main_sel_q;
    main_data_d = main_data_q;
    skid_ir_d   = skid_ir_q;
    skid_we_d   = skid_we_q;
    skid_reg_d  = skid_reg_q;
    skid_sel_d  = skid_sel_q;
    skid_data_d = skid_data_q;
    if (move_skid) begin
      main_ir_d   = skid_ir_q;
      main_we_d   = skid_we_q;
      main_reg_d  = skid_reg_q;
      main_sel_d  = skid_sel_q;
      main_data_d = skid_data_q;
    end else if (load_main) begin
      main_ir_d   = ir_i;
      main_we_d   = in_we;
      main_reg_d  = in_reg;
      main_sel_d  = in_sel;
      main_data_d = in_data;
    end
    if (load_skid) begin
      skid_ir_d   = ir_i;
      skid_we_d   = in_we;
      skid_reg_d  = in_reg;
      skid_sel_d  = in_sel;
      skid_data_d = in_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_ir_q   <= '0;
      main_we_q   <= 1'b0;
      main_reg_q  <= NOP_IDX;
      main_sel_q  <= 1'b0;
      main_data_q <= '0;
      skid_ir_q   <= '0;
      skid_we_q   <= 1'b0;
      skid_reg_q  <= NOP_IDX;
      skid_sel_q  <= 1'b0;
      skid_data_q <= '0;
    end else begin
      main_ir_q   <= main_ir_d;
      main_we_q   <= main_we_d;
      main_reg_q  <= main_reg_d;
      main_sel_q  <= main_sel_d;
      main_data_q <= main_data_d;
      skid_ir_q   <= skid_ir_d;
      skid_we_q   <= skid_we_d;
      skid_reg_q  <= skid_reg_d;
      skid_sel_q  <= skid_sel_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_valid_o = main_valid;
  assign ir_o        = main_ir_q;
  assign wb_we_o     = main_valid & main_we_q;
  assign wb_reg_o    = main_reg_q;
  assign wb_sel_o    = main_sel_q;
  assign wb_data_o   = main_data_q;

`ifdef MEM_WB_FWD_EN
  assign fwd_we_o   = main_valid & main_we_q;
  assign fwd_reg_o  = main_reg_q;
  assign fwd_data_o = main_data_q;
`else
  assign fwd_we_o   = 1'b0;
  assign fwd_reg_o  = NOP_IDX;
  assign fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] ir_i = '0;
  logic [31:0] alu_data_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] ir_o;
  logic        wb_we_o;
  logic [4:0]  wb_reg_o;
  logic        wb_sel_o;
  logic [31:0] wb_data_o;
  logic        fwd_we_o;
  logic [4:0]  fwd_reg_o;
  logic [31:0] fwd_data_o;

  mem_wb_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ir_i(ir_i), .alu_data_i(alu_data_i), .mem_data_i(mem_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ir_o(ir_o), .wb_we_o(wb_we_o), .wb_reg_o(wb_reg_o),
    .wb_sel_o(wb_sel_o), .wb_data_o(wb_data_o),
    .fwd_we_o(fwd_we_o), .fwd_reg_o(fwd_reg_o), .fwd_data_o(fwd_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] ir;
    logic        we;
    logic [4:0]  rg;
    logic        sel;
    logic [31:0] data;
  } ent_t;

  ent_t exp_q[$];
  ent_t last_e;
  bit   model_ready = 1'b1;
  int   total = 0;
  int   bad   = 0;

  function automatic ent_t model(input logic [31:0] ir, input logic [31:0] alu,
                                 input logic [31:0] mem);
    ent_t e;
    int   op;
    op     = int'(ir[31:28]);
    e.ir   = ir;
    e.we   = (op == 0 || op == 2 || op == 3 || op == 4 || op == 5 || op == 6 || op == 9);
    e.rg   = e.we ? ir[27:23] : 5'd31;
    e.sel  = (op != 0);
    e.data = e.sel ? alu : mem;
    return e;
  endfunction

  function automatic ent_t reset_ent();
    ent_t e;
    e.ir = '0; e.we = 1'b0; e.rg = 5'd31; e.sel = 1'b0; e.data = '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue side: expected entries are queued on the edge that accepts them
  always @(posedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      last_e      = reset_ent();
      model_ready = 1'b1;
    end else if (flush_i) begin
      exp_q.delete();
    end else if (in_valid_i && model_ready) begin
      exp_q.push_back(model(ir_i, alu_data_i, mem_data_i));
    end
  end

  // Monitor: compares what the DUT presents, pops on out_fire
  always @(negedge clk_i) begin
    ent_t e;
    bit   v;
    if (!rst_i) begin
      v = (exp_q.size() > 0);
      e = v ? exp_q[0] : last_e;
      chk("out_valid", {31'b0, out_valid_o}, {31'b0, v});
      chk("in_ready", {31'b0, in_ready_o}, {31'b0, exp_q.size() < 2});
      chk("wb_we", {31'b0, wb_we_o}, {31'b0, v & e.we});
      chk("ir", ir_o, e.ir);
      chk("wb_reg", {27'b0, wb_reg_o}, {27'b0, e.rg});
      chk("wb_sel", {31'b0, wb_sel_o}, {31'b0, e.sel});
      chk("wb_data", wb_data_o, e.data);
`ifdef MEM_WB_FWD_EN
      chk("fwd_we", {31'b0, fwd_we_o}, {31'b0, v & e.we});
      chk("fwd_reg", {27'b0, fwd_reg_o}, {27'b0, e.rg});
      chk("fwd_data", fwd_data_o, e.data);
`else
      chk("fwd_we", {31'b0, fwd_we_o}, 32'd0);
      chk("fwd_reg", {27'b0, fwd_reg_o}, 32'd31);
      chk("fwd_data", fwd_data_o, 32'd0);
`endif
      last_e      = e;
      model_ready = (exp_q.size() < 2);
      if (v && out_ready_i) void'(exp_q.pop_front());
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ir, input logic [31:0] alu,
                     input logic [31:0] mem, input logic ordy, input logic fl);
    in_valid_i = v; ir_i = ir; alu_data_i = alu; mem_data_i = mem;
    out_ready_i = ordy; flush_i = fl;
    @(posedge clk_i); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    cyc(0, 0, 0, 0, 1, 0);
    // ADDU rd=1, LW rd=2, SW
    cyc(1, 32'h3080_0000, 32'h11, 32'h22, 1, 0);
    cyc(1, 32'h0100_0000, 32'h33, 32'hDEAD, 1, 0);
    cyc(1, 32'h1000_0000, 32'h44, 32'h55, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    // Stall: A, B accepted, C blocked, then drain in order
    cyc(1, 32'h3100_0000, 32'hA, 32'h0, 0, 0);
    cyc(1, 32'h4180_0000, 32'hB, 32'h0, 0, 0);
    cyc(1, 32'h6200_0000, 32'hC, 32'h0, 0, 0);
    cyc(1, 32'h6200_0000, 32'hC, 32'h0, 0, 0);
    cyc(1, 32'h6200_0000, 32'hC, 32'h0, 1, 0);
    cyc(1, 32'h6200_0000, 32'hC, 32'h0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    // Fill to FULL, flush with a valid input, then opcode 0xF
    cyc(1, 32'h2280_0000, 32'h1, 32'h0, 0, 0);
    cyc(1, 32'h5300_0000, 32'h2, 32'h0, 0, 0);
    cyc(1, 32'h6380_0000, 32'hBAD, 32'h0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'hF380_0000, 32'h77, 32'h88, 1, 0);
    // MUL rd=7 held in main
    cyc(1, 32'h6380_0000, 32'h1234, 32'h0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    // Randomized traffic with a reset in the middle of a stall
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
      end
      cyc($urandom_range(0, 9) < 7, $urandom(), $urandom(), $urandom(),
          $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM→WB pipeline register with valid/ready handshake, 2-entry skid buffer, flush, and registered writeback-control decode.
- Sits between the data-memory stage and the register-file write port.
- Adds stall support, a flush path, and a pre-muxed writeback datum to the existing unconditional MEM/WB latch.

Parameters:
- DATA_W, 32, width of ALU result, memory data and writeback data.
- IR_W, 32, instruction word width; opcode is always IR[IR_W-1:IR_W-4].
- REG_W, 5, register index width; destination is IR[IR_W-5:IR_W-4-REG_W].
- NOP_REG, 31, value driven on wb_reg_o when no write occurs.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all held and incoming entries.
- in_valid_i  in  1  MEM stage presents an entry.
- in_ready_o  out  1  stage can accept an entry.
- ir_i  in  IR_W  instruction word.
- alu_data_i  in  DATA_W  ALU/immediate result.
- mem_data_i  in  DATA_W  load data.
- out_valid_o  out  1  WB entry valid.
- out_ready_i  in  1  WB consumes the entry.
- ir_o  out  IR_W  held instruction.
- wb_we_o  out  1  register write enable; already qualified with out_valid_o.
- wb_reg_o  out  REG_W  destination register, or NOP_REG.
- wb_sel_o  out  1  0 = memory data, 1 = ALU data.
- wb_data_o  out  DATA_W  selected writeback datum.
- fwd_we_o  out  1  forwarding valid (optional feature).
- fwd_reg_o  out  REG_W  forwarding register (optional feature).
- fwd_data_o  out  DATA_W  forwarding data (optional feature).

Behaviour:
- Clocking/reset: single clock clk_i; reset rst_i is synchronous, active-high. All state is updated on the rising edge.
- Reset values: out_valid_o=0, wb_we_o=0, wb_sel_o=0, wb_reg_o=NOP_REG, wb_data_o=0, ir_o=0, skid empty, in_ready_o=1 on the first cycle after reset.
- Opcode decode, evaluated at capture time and stored with the entry:
  - Opcodes LW=0, SW=1, LI=2, ADDU=3, ADDIU=4, SLL=5, MUL=6, BGE=7, J=8, MULI=9.
  - we=1 for {0,2,3,4,5,6,9}; otherwise we=0.
  - When we=0, reg=NOP_REG; when we=1, reg=destination field.
  - sel=0 only for LW; otherwise sel=1.
  - Stored data = sel ? alu_data_i : mem_data_i.
  - Opcodes 10–15: we=0, sel=1.
- Handshake definitions: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- in_ready_o is registered and equals !skid_valid; it has no combinational path from out_ready_i.
- States by occupancy:
  - EMPTY (main and skid empty): in_fire → main loaded, go to ONE. Latency from in_fire to out_valid_o is 1 cycle.
  - ONE (main full): out_fire & in_fire → main reloaded, stay in ONE. out_fire only → EMPTY. in_fire only → skid loaded, go to FULL.
  - FULL (main and skid full, in_ready_o=0): out_fire → skid moves to main, go to ONE. No input is accepted in this cycle; in_ready_o rises next cycle.
- Ordering: strict FIFO; no entry is dropped or duplicated except on flush.
- Flush: flush_i=1 → next state EMPTY, and that cycle's input is discarded. Priority: rst_i > flush_i > handshake.
- Outputs while out_valid_o=0: wb_we_o=0; other outputs hold their last values.
- out_ready_i=0 with out_valid_o=1: all outputs stable until out_fire.
- Reset mid-stall: identical to reset from idle.

Optional Feature:
- Macro: MEM_WB_FWD_EN.
- Defined: fwd_we_o = out_valid_o & main.we; fwd_reg_o = main.reg; fwd_data_o = main.data. All are combinational from the main register, for EX-stage bypass.
- Undefined: fwd_we_o=0, fwd_reg_o=NOP_REG, fwd_data_o=0. Ports remain present and no forwarding logic is synthesised.

Test Plan:
- Reset, then ir_i=0x3080_0000 (ADDU, rd=1), alu=0x11, mem=0x22, in_valid=1, out_ready=1 → next cycle: out_valid=1, wb_we=1, wb_reg=1, wb_sel=1, wb_data=0x11.
- LW ir=0x0100_0000 (rd=2), mem=0xDEAD → wb_sel=0, wb_data=0xDEAD. SW ir=0x1000_0000 → wb_we=0, wb_reg=31.
- Hold out_ready=0 and push A, B, C back-to-back → A and B accepted, in_ready=0 while C is presented. Release out_ready → outputs A, B, then C in order; no loss.
- FULL state with flush_i=1 and in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears at the output.
- Opcode 0xF with in_valid=1 → wb_we=0, wb_reg=NOP_REG, wb_sel=1.
- With MEM_WB_FWD_EN: MUL rd=7 held in main → fwd_we=1, fwd_reg=7, fwd_data=alu value. Without the macro → fwd_we=0 always.
